// File: rtl/bounce_pkg.sv
// rtl/bounce_pkg.sv - shared types and constants for the switch-bounce emulator
package bounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_GLITCH_ON  = 2'd1,
        ST_GLITCH_OFF = 2'd2,
        ST_SETTLE     = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Galois form, right shift: feedback enters where the taps are set.
    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/bounce_gen_if.sv
// rtl/bounce_gen_if.sv - test-control side and contact side of the bounce emulator
interface bounce_gen_if;
    logic en;
    logic level_in;
    logic sw_out;
    logic busy;
    logic done;

    modport master (output en, output level_in, input sw_out, input busy, input done);
    modport slave  (input en, input level_in, output sw_out, output busy, output done);
endinterface

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Galois LFSR, reloads the seed on reset
module lfsr16
    import bounce_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= seed;
        end else begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/bounce_gen.sv
// rtl/bounce_gen.sv - turns a clean level into a bouncing contact waveform
// paced by a 2^N-clock tick, glitch count and widths drawn from an LFSR.
module bounce_gen
    import bounce_pkg::*;
#(
    parameter int          N          = 2,
    parameter logic [15:0] SEED       = DEFAULT_SEED,
    parameter int          GLITCH_MAX = 4,
    parameter int          HOLD_TICKS = 4
) (
    input  logic        clk,
    input  logic        reset,
    bounce_gen_if.slave bus
);

    localparam int              DWELL_MAX = (HOLD_TICKS > 4) ? HOLD_TICKS : 4;
    localparam int              DW        = $clog2(DWELL_MAX + 1);
    localparam logic [3:0]      GMAX      = 4'(GLITCH_MAX);
    localparam logic [DW-1:0]   HOLD      = DW'(HOLD_TICKS);

    state_t        r_state;
    state_t        w_next_state;
    logic [N-1:0]  r_q;
    logic          r_target;
    logic          r_sw;
    logic          r_busy;
    logic          r_done;
    logic [3:0]    r_gcnt;
    logic [DW-1:0] r_dwell;

    logic          w_target_next;
    logic          w_sw_next;
    logic          w_busy_next;
    logic          w_done_next;
    logic [3:0]    w_gcnt_next;
    logic [DW-1:0] w_dwell_next;

    logic [15:0]   w_lfsr;
    logic          w_tick;
    logic          w_expire;
    logic [3:0]    w_gcnt_raw;
    logic [3:0]    w_gcnt_load;
    logic [DW-1:0] w_dwell_load;
    logic          w_unused_lfsr;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (SEED),
        .q     (w_lfsr)
    );

    assign w_unused_lfsr = ^w_lfsr[15:3];
    assign w_tick        = (r_q == '0);
    assign w_expire      = w_tick && (r_dwell == DW'(1));
    assign w_dwell_load  = DW'(w_lfsr[1:0]) + DW'(1);
    assign w_gcnt_raw    = {1'b0, w_lfsr[2:0]} + 4'd1;
    assign w_gcnt_load   = (w_gcnt_raw > GMAX) ? GMAX : w_gcnt_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (!bus.en) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:       if (bus.level_in != r_sw) w_next_state = ST_GLITCH_ON;
                ST_GLITCH_ON:  if (w_expire) w_next_state = ST_GLITCH_OFF;
                ST_GLITCH_OFF: if (w_expire) w_next_state = (r_gcnt == 4'd1) ? ST_SETTLE : ST_GLITCH_ON;
                ST_SETTLE:     if (w_expire) w_next_state = ST_IDLE;
                default:       w_next_state = ST_IDLE;
            endcase
        end
    end

    // A tick seen in the entry cycle already counts; the entry edge itself never does.
    always_comb begin
        w_target_next = r_target;
        w_gcnt_next   = r_gcnt;
        w_dwell_next  = r_dwell;
        w_sw_next     = r_sw;
        w_busy_next   = (w_next_state != ST_IDLE);
        w_done_next   = 1'b0;
        if (!bus.en) begin
            w_sw_next = bus.level_in;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.level_in != r_sw) begin
                        w_target_next = bus.level_in;
                        w_gcnt_next   = w_gcnt_load;
                        w_dwell_next  = w_dwell_load;
                        w_sw_next     = bus.level_in;
                    end
                end
                ST_GLITCH_ON: begin
                    if (w_expire) begin
                        w_dwell_next = w_dwell_load;
                        w_sw_next    = ~r_target;
                    end else if (w_tick) begin
                        w_dwell_next = r_dwell - DW'(1);
                    end
                end
                ST_GLITCH_OFF: begin
                    if (w_expire) begin
                        w_gcnt_next  = r_gcnt - 4'd1;
                        w_dwell_next = (r_gcnt == 4'd1) ? HOLD : w_dwell_load;
                        w_sw_next    = r_target;
                    end else if (w_tick) begin
                        w_dwell_next = r_dwell - DW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (w_expire) begin
                        w_done_next = 1'b1;
                    end else if (w_tick) begin
                        w_dwell_next = r_dwell - DW'(1);
                    end
                end
                default: w_sw_next = r_sw;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q      <= '0;
            r_target <= 1'b0;
            r_gcnt   <= 4'd0;
            r_dwell  <= '0;
            r_sw     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_q      <= r_q + N'(1);
            r_target <= w_target_next;
            r_gcnt   <= w_gcnt_next;
            r_dwell  <= w_dwell_next;
            r_sw     <= w_sw_next;
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
        end
    end

    assign bus.sw_out = r_sw;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;

endmodule
